// File: rtl/tcp_misc_pkg.sv
// Scheduler command format shared by the timeout engine, RX pipeline and TX scheduler.
package tcp_misc_pkg;
   import tcp_pkg::*;

   typedef enum logic [1:0] {
      SC_NOP   = 2'd0,
      SC_SET   = 2'd1,
      SC_CLEAR = 2'd2
   } sched_set_clear_e;

   typedef struct packed {
      logic [FLOWID_W-1:0] flowid;
      sched_set_clear_e    rt_pend_set_clear;
      sched_set_clear_e    ack_pend_set_clear;
      sched_set_clear_e    data_pend_set_clear;
   } sched_cmd_struct;

   // Encoding 2'd3 falls through to the hold case.
   function automatic logic sc_apply(input logic cur, input sched_set_clear_e sc);
      logic res;
      res = cur;
      if (sc == SC_SET) begin
         res = 1'b1;
      end else if (sc == SC_CLEAR) begin
         res = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/tcp_pkg.sv
// Flow-count parameters shared across the TCP offload engines.
package tcp_pkg;

   localparam int unsigned MAX_TCP_FLOWS = 16;
   localparam int unsigned FLOWID_W      = $clog2(MAX_TCP_FLOWS);

endpackage

// File: rtl/tx_pend_flag_table.sv
// Per-flow rt/ack/data pending flags with grant-clear < src1 < src0 update precedence.
module tx_pend_flag_table
   import tcp_misc_pkg::*;
#(
   parameter int unsigned NUM_FLOWS = tcp_pkg::MAX_TCP_FLOWS,
   parameter int unsigned FLOWID_W  = $clog2(NUM_FLOWS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                src0_acc_i,
   input  sched_cmd_struct     src0_cmd_i,
   input  logic                src1_acc_i,
   input  sched_cmd_struct     src1_cmd_i,
   input  logic                gclr_i,
   input  logic [FLOWID_W-1:0] gclr_flowid_i,
   input  logic [2:0]          gclr_mask_i,
   input  logic [FLOWID_W-1:0] rd_idx_i,
   output logic [2:0]          rd_pend_c_o
);

   localparam int unsigned CMD_FLOWID_W = tcp_pkg::FLOWID_W;

   logic [NUM_FLOWS-1:0] rt_q, ack_q, data_q;
   logic [NUM_FLOWS-1:0] rt_d, ack_d, data_d;

   // Later assignments win, so apply sources in ascending priority.
   always_comb begin
      rt_d   = rt_q;
      ack_d  = ack_q;
      data_d = data_q;
      for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
         if (gclr_i && (gclr_flowid_i == FLOWID_W'(i))) begin
            if (gclr_mask_i[2]) rt_d[i]   = 1'b0;
            if (gclr_mask_i[1]) ack_d[i]  = 1'b0;
            if (gclr_mask_i[0]) data_d[i] = 1'b0;
         end
         if (src1_acc_i && (src1_cmd_i.flowid == CMD_FLOWID_W'(i))) begin
            rt_d[i]   = sc_apply(rt_d[i],   src1_cmd_i.rt_pend_set_clear);
            ack_d[i]  = sc_apply(ack_d[i],  src1_cmd_i.ack_pend_set_clear);
            data_d[i] = sc_apply(data_d[i], src1_cmd_i.data_pend_set_clear);
         end
         if (src0_acc_i && (src0_cmd_i.flowid == CMD_FLOWID_W'(i))) begin
            rt_d[i]   = sc_apply(rt_d[i],   src0_cmd_i.rt_pend_set_clear);
            ack_d[i]  = sc_apply(ack_d[i],  src0_cmd_i.ack_pend_set_clear);
            data_d[i] = sc_apply(data_d[i], src0_cmd_i.data_pend_set_clear);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rt_q   <= '0;
         ack_q  <= '0;
         data_q <= '0;
      end else begin
         rt_q   <= rt_d;
         ack_q  <= ack_d;
         data_q <= data_d;
      end
   end

   assign rd_pend_c_o = {rt_q[rd_idx_i], ack_q[rd_idx_i], data_q[rd_idx_i]};

endmodule

// File: rtl/tx_pend_sched.sv
// Round-robin transmit scheduler: scans per-flow pending flags and offers one flow at a time.
module tx_pend_sched
   import tcp_misc_pkg::*;
#(
   parameter int unsigned NUM_FLOWS = tcp_pkg::MAX_TCP_FLOWS,
   parameter int unsigned FLOWID_W  = $clog2(NUM_FLOWS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                src0_cmd_val,
   input  sched_cmd_struct     src0_cmd_data,
   output logic                src0_cmd_rdy,
   input  logic                src1_cmd_val,
   input  sched_cmd_struct     src1_cmd_data,
   output logic                src1_cmd_rdy,
   output logic                sched_tx_val,
   output logic [FLOWID_W-1:0] sched_tx_flowid,
   output logic [2:0]          sched_tx_pend,
   input  logic                sched_tx_rdy
);

   typedef enum logic {
      ST_SCAN  = 1'b0,
      ST_OFFER = 1'b1
   } sched_state_e;

   sched_state_e        state_q, state_d;
   logic [FLOWID_W-1:0] scan_idx_q, scan_idx_d;
   logic [FLOWID_W-1:0] flowid_q, flowid_d;
   logic [2:0]          pend_q, pend_d;
   logic                val_q, val_d;
   logic                cmd_rdy_q;
   logic                gclr_c;
   logic [2:0]          rd_pend_c;

   tx_pend_flag_table #(
      .NUM_FLOWS (NUM_FLOWS),
      .FLOWID_W  (FLOWID_W)
   ) u_flag_table (
      .clk           (clk),
      .rst           (rst),
      .src0_acc_i    (src0_cmd_val & cmd_rdy_q),
      .src0_cmd_i    (src0_cmd_data),
      .src1_acc_i    (src1_cmd_val & cmd_rdy_q),
      .src1_cmd_i    (src1_cmd_data),
      .gclr_i        (gclr_c),
      .gclr_flowid_i (flowid_q),
      .gclr_mask_i   (pend_q),
      .rd_idx_i      (scan_idx_q),
      .rd_pend_c_o   (rd_pend_c)
   );

   // The pointer stays on the offered flow until the grant so the next scan starts after it.
   always_comb begin
      state_d    = state_q;
      scan_idx_d = scan_idx_q;
      flowid_d   = flowid_q;
      pend_d     = pend_q;
      val_d      = val_q;
      gclr_c     = 1'b0;
      case (state_q)
         ST_SCAN: begin
            if (|rd_pend_c) begin
               flowid_d = scan_idx_q;
               pend_d   = rd_pend_c;
               val_d    = 1'b1;
               state_d  = ST_OFFER;
            end else begin
               scan_idx_d = scan_idx_q + FLOWID_W'(1);
            end
         end
         ST_OFFER: begin
            if (sched_tx_rdy) begin
               gclr_c     = 1'b1;
               val_d      = 1'b0;
               scan_idx_d = scan_idx_q + FLOWID_W'(1);
               state_d    = ST_SCAN;
            end
         end
         default: begin
            state_d = ST_SCAN;
            val_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_SCAN;
         scan_idx_q <= '0;
         flowid_q   <= '0;
         pend_q     <= '0;
         val_q      <= 1'b0;
         cmd_rdy_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         scan_idx_q <= scan_idx_d;
         flowid_q   <= flowid_d;
         pend_q     <= pend_d;
         val_q      <= val_d;
         cmd_rdy_q  <= 1'b1;
      end
   end

   assign src0_cmd_rdy    = cmd_rdy_q;
   assign src1_cmd_rdy    = cmd_rdy_q;
   assign sched_tx_val    = val_q;
   assign sched_tx_flowid = flowid_q;
   assign sched_tx_pend   = pend_q;

endmodule
